btb_assoc_predictor: RTL and testbench

//  Parametrised fully-associative branch target buffer with N-bit saturating direction counters.

---
 rtl/btb_assoc_predictor_pkg.sv | 17 +
 rtl/sat_counter_upd.sv | 24 ++
 rtl/btb_assoc_predictor.sv | 160 ++++++++++++++++
 tb/tb_btb_assoc_predictor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/btb_assoc_predictor_pkg.sv
// Shared helpers for the associative BTB.
//   clog2_min1 : index width for a table of n entries, never below 1 bit
//   ctr_init   : weakly-taken counter value (MSB set, rest clear) for a w-bit counter
package btb_assoc_predictor_pkg;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int ctr_init(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/sat_counter_upd.sv
// Combinational CTR_W-bit saturating up/down step.
//   ctr_i : current counter value
//   inc_i : 1 = count up (saturate at all-ones), 0 = count down (saturate at 0)
//   ctr_o : stepped counter value
module sat_counter_upd #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             inc_i,
    output logic [CTR_W-1:0] ctr_o
);

    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != CTR_MAX) ctr_o = ctr_i + CTR_W'(1);
        end else begin
            if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
        end
    end

endmodule

// File: rtl/btb_assoc_predictor.sv
// Fully-associative branch target buffer with saturating direction counters.
// Combinational lookup for the fetch PC; resolved branches train the table on
// the next clock edge. Round-robin victim selection once the table is full.
//   clk, reset             : clock, async active-low reset (clears table)
//   lookup_pc              : fetch PC
//   lookup_hit/taken/target/idx : lookup result (all zero on miss)
//   upd_en/pc/taken/target : training port for resolved branches
//   inv_all                : bulk invalidate, wins over a same-cycle update
//   occupancy              : number of valid entries
module btb_assoc_predictor
    import btb_assoc_predictor_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 8,
    parameter int CTR_W   = 2,
    parameter int BYPASS  = 0,
    localparam int IDX_W  = clog2_min1(ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              lookup_hit,
    output logic              lookup_taken,
    output logic [ADDR_W-1:0] lookup_target,
    output logic [IDX_W-1:0]  lookup_idx,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              inv_all,
    output logic [IDX_W:0]    occupancy
);

    localparam int               TAG_W    = ADDR_W - 2;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
    localparam logic [IDX_W:0]   OCC_FULL = (IDX_W+1)'(ENTRIES);
    localparam logic [IDX_W-1:0] RR_LAST  = IDX_W'(ENTRIES - 1);

    logic [ENTRIES-1:0]             valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q,   tag_d;
    logic [ENTRIES-1:0][ADDR_W-1:0] tgt_q,   tgt_d;
    logic [ENTRIES-1:0][CTR_W-1:0]  ctr_q,   ctr_d;
    logic [IDX_W-1:0]               rr_q,    rr_d;
    logic [IDX_W:0]                 occ_q,   occ_d;

    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, upd_hit, full, byp;
    logic [IDX_W-1:0] lk_idx, upd_idx, free_idx, victim;
    logic [CTR_W-1:0] ctr_upd;

    // Low PC bits never take part in matching.
    logic unused_lowbits;
    assign unused_lowbits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_tag  = lookup_pc[ADDR_W-1:2];
    assign upd_tag = upd_pc[ADDR_W-1:2];

    // Priority encoders: descending scan so the lowest index wins. At most
    // one entry can match a tag, so the match encoders only matter for the
    // free-slot search.
    always_comb begin
        lk_hit   = 1'b0;
        lk_idx   = '0;
        upd_hit  = 1'b0;
        upd_idx  = '0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == lk_tag) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (valid_q[i] && tag_q[i] == upd_tag) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    assign full   = (occ_q == OCC_FULL);
    assign victim = full ? rr_q : free_idx;

    // Single counter stepper shared by training and the bypass view: bypass
    // only applies when both ports address the same tag, i.e. the same entry.
    sat_counter_upd #(.CTR_W(CTR_W)) u_ctr (
        .ctr_i (ctr_q[upd_idx]),
        .inc_i (upd_taken),
        .ctr_o (ctr_upd)
    );

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        rr_d    = rr_q;
        occ_d   = occ_q;
        if (inv_all) begin
            valid_d = '0;
            rr_d    = '0;
            occ_d   = '0;
        end else if (upd_en) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = ctr_upd;
                if (upd_taken) tgt_d[upd_idx] = upd_target;
            end else if (upd_taken) begin
                valid_d[victim] = 1'b1;
                tag_d[victim]   = upd_tag;
                tgt_d[victim]   = upd_target;
                ctr_d[victim]   = CTR_INIT;
                if (full) rr_d  = (rr_q == RR_LAST) ? '0 : rr_q + IDX_W'(1);
                else      occ_d = occ_q + (IDX_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            ctr_q   <= '0;
            rr_q    <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
            rr_q    <= rr_d;
            occ_q   <= occ_d;
        end
    end

    // Bypass is gated by reset so outputs stay zero while reset is held.
    assign byp = (BYPASS != 0) && reset && upd_en && !inv_all && (upd_tag == lk_tag);

    always_comb begin
        lookup_hit    = lk_hit;
        lookup_idx    = lk_idx;
        lookup_taken  = lk_hit & ctr_q[lk_idx][CTR_W-1];
        lookup_target = lk_hit ? tgt_q[lk_idx] : '0;
        if (byp) begin
            if (upd_hit) begin
                lookup_hit    = 1'b1;
                lookup_idx    = upd_idx;
                lookup_taken  = ctr_upd[CTR_W-1];
                lookup_target = upd_taken ? upd_target : tgt_q[upd_idx];
            end else if (upd_taken) begin
                lookup_hit    = 1'b1;
                lookup_idx    = victim;
                lookup_taken  = CTR_INIT[CTR_W-1];
                lookup_target = upd_target;
            end
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_btb_assoc_predictor.sv
module tb_btb_assoc_predictor;

    localparam int NE = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0, upd_en = 1'b0, upd_taken = 1'b0, inv_all = 1'b0;
    logic [31:0] lookup_pc = '0, upd_pc = '0, upd_target = '0;

    logic        hit0, tk0, hit1, tk1;
    logic [31:0] tgt0, tgt1;
    logic [2:0]  idx0, idx1;
    logic [3:0]  occ0, occ1;

    btb_assoc_predictor #(.ADDR_W(32), .ENTRIES(NE), .CTR_W(2), .BYPASS(0)) u0 (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .lookup_hit(hit0), .lookup_taken(tk0), .lookup_target(tgt0), .lookup_idx(idx0),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .inv_all(inv_all), .occupancy(occ0));

    btb_assoc_predictor #(.ADDR_W(32), .ENTRIES(NE), .CTR_W(2), .BYPASS(1)) u1 (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .lookup_hit(hit1), .lookup_taken(tk1), .lookup_target(tgt1), .lookup_idx(idx1),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .inv_all(inv_all), .occupancy(occ1));

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [2:0]  idx;
        logic [3:0]  occ;
    } exp_t;
    typedef struct { exp_t e0; exp_t e1; } pair_t;

    pair_t sb[$];
    int checks = 0, errors = 0;

    // Reference table: plain arrays, counters as ints in 0..3.
    bit          mv[NE];
    logic [29:0] mt[NE];
    logic [31:0] mg[NE];
    int          mc[NE];
    int          mrr;

    function automatic void model_clear();
        for (int i = 0; i < NE; i++) mv[i] = 0;
        mrr = 0;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < NE; i++) if (mv[i]) c++;
        return c;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        int h = -1, v = -1;
        for (int i = 0; i < NE; i++) if (mv[i] && mt[i] == pc[31:2]) h = i;
        if (h >= 0) begin
            if (tk) begin
                if (mc[h] < 3) mc[h] = mc[h] + 1;
                mg[h] = tg;
            end else if (mc[h] > 0) mc[h] = mc[h] - 1;
        end else if (tk) begin
            for (int i = NE - 1; i >= 0; i--) if (!mv[i]) v = i;
            if (v < 0) begin
                v   = mrr;
                mrr = (mrr + 1) % NE;
            end
            mv[v] = 1; mt[v] = pc[31:2]; mg[v] = tg; mc[v] = 2;
        end
    endfunction

    function automatic exp_t model_lookup(input logic [31:0] pc);
        exp_t e;
        e.hit = 0; e.taken = 0; e.tgt = '0; e.idx = '0;
        e.occ = 4'(model_count());
        for (int i = 0; i < NE; i++)
            if (mv[i] && mt[i] == pc[31:2]) begin
                e.hit = 1; e.taken = (mc[i] >= 2); e.tgt = mg[i]; e.idx = 3'(i);
            end
        return e;
    endfunction

    // Bypass view: lookup against the table as it will be after this update.
    function automatic exp_t expect_bypass();
        exp_t e;
        bit sv[NE]; logic [29:0] st[NE]; logic [31:0] sg[NE]; int sc[NE]; int srr;
        logic [3:0] occ_now;
        if (reset && upd_en && !inv_all && upd_pc[31:2] == lookup_pc[31:2]) begin
            occ_now = 4'(model_count());
            sv = mv; st = mt; sg = mg; sc = mc; srr = mrr;
            model_update(upd_pc, upd_taken, upd_target);
            e = model_lookup(lookup_pc);
            e.occ = occ_now;
            mv = sv; mt = st; mg = sg; mc = sc; mrr = srr;
        end else e = model_lookup(lookup_pc);
        return e;
    endfunction

    function automatic void cmp(input string nm, input exp_t e, input logic h, input logic t,
                                input logic [31:0] g, input logic [2:0] i, input logic [3:0] o);
        checks++;
        if (h !== e.hit || t !== e.taken || g !== e.tgt || i !== e.idx || o !== e.occ) begin
            errors++;
            $display("FAIL %s @%0t: got hit=%0b taken=%0b tgt=%h idx=%0d occ=%0d, want hit=%0b taken=%0b tgt=%h idx=%0d occ=%0d",
                     nm, $time, h, t, g, i, o, e.hit, e.taken, e.tgt, e.idx, e.occ);
        end
    endfunction

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, got, want);
        end
    endfunction

    // Monitor: outputs are combinational, so every negedge presents one result.
    always @(negedge clk) begin
        pair_t p;
        if (sb.size() > 0) begin
            p = sb.pop_front();
            cmp("bypass0", p.e0, hit0, tk0, tgt0, idx0, occ0);
            cmp("bypass1", p.e1, hit1, tk1, tgt1, idx1, occ1);
        end
    end

    // One cycle: commit the previous cycle's inputs to the model at the edge,
    // then drive new inputs and queue the expected lookup result.
    task automatic step(input logic rst, input logic en, input logic tk, input logic inv,
                        input logic [31:0] upc, input logic [31:0] utgt, input logic [31:0] lpc);
        pair_t p;
        @(posedge clk);
        if (!reset || inv_all) model_clear();
        else if (upd_en) model_update(upd_pc, upd_taken, upd_target);
        #1;
        reset = rst; upd_en = en; upd_taken = tk; inv_all = inv;
        upd_pc = upc; upd_target = utgt; lookup_pc = lpc;
        if (!rst) model_clear();
        p.e0 = model_lookup(lpc);
        p.e1 = expect_bypass();
        sb.push_back(p);
    endtask

    task automatic idle(input logic [31:0] lpc);
        step(1, 0, 0, 0, 32'h0, 32'h0, lpc);
    endtask

    initial begin
        logic [31:0] upc, lpc;
        model_clear();

        // reset state
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'h100);
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'h100);
        #1 chk("rst_hit", 32'(hit0), 0); chk("rst_occ", 32'(occ0), 0);

        // allocate 0x100 -> 0x200, bypass sees it the same cycle
        step(1, 1, 1, 0, 32'h100, 32'h200, 32'h100);
        #1 chk("nobyp_same_hit", 32'(hit0), 0); chk("byp_same_hit", 32'(hit1), 1);
        chk("byp_same_tgt", tgt1, 32'h200);
        idle(32'h100);
        #1 chk("alloc_hit", 32'(hit0), 1); chk("alloc_taken", 32'(tk0), 1);
        chk("alloc_tgt", tgt0, 32'h200); chk("alloc_occ", 32'(occ0), 1);
        idle(32'h102);
        #1 chk("lowbits_hit", 32'(hit0), 1);

        // counter walk down, floor, then up to saturation
        repeat (2) step(1, 1, 0, 0, 32'h100, 32'h0, 32'h100);
        idle(32'h100);
        #1 chk("ctr0_hit", 32'(hit0), 1); chk("ctr0_taken", 32'(tk0), 0);
        step(1, 1, 0, 0, 32'h100, 32'h0, 32'h100);
        repeat (4) step(1, 1, 1, 0, 32'h100, 32'h200, 32'h100);
        idle(32'h100);
        #1 chk("sat_taken", 32'(tk0), 1);
        step(1, 1, 0, 0, 32'h100, 32'h0, 32'h100);
        idle(32'h100);
        #1 chk("sat_one_nt_taken", 32'(tk0), 1);

        // fill the table, then round-robin replacement
        step(1, 0, 0, 1, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 8; k++) step(1, 1, 1, 0, 32'(k * 4), 32'(32'h800 + k * 4), 32'h0);
        step(1, 1, 1, 0, 32'h40, 32'h900, 32'h40);
        idle(32'h00);
        #1 chk("evict_miss", 32'(hit0), 0);
        idle(32'h40);
        #1 chk("evict_hit", 32'(hit0), 1); chk("evict_idx0", 32'(idx0), 0);
        step(1, 1, 1, 0, 32'h44, 32'h904, 32'h44);
        idle(32'h44);
        #1 chk("evict_idx1", 32'(idx0), 1);
        for (int k = 0; k < 8; k++) step(1, 1, 1, 0, 32'(32'h80 + k * 4), 32'(32'hA00 + k), 32'h0);
        idle(32'h80);
        #1 chk("full_occ", 32'(occ0), 8); chk("wrap_idx", 32'(idx0), 2);

        // invalidate beats same-cycle update; not-taken miss allocates nothing
        step(1, 1, 1, 1, 32'h500, 32'h1, 32'h500);
        idle(32'h500);
        #1 chk("inv_occ", 32'(occ0), 0); chk("inv_hit", 32'(hit0), 0);
        step(1, 1, 0, 0, 32'h600, 32'h0, 32'h600);
        idle(32'h600);
        #1 chk("nt_miss_occ", 32'(occ0), 0);

        // bypass vs registered view
        step(1, 1, 1, 0, 32'h300, 32'h400, 32'h300);
        #1 chk("byp1_hit", 32'(hit1), 1); chk("byp1_tgt", tgt1, 32'h400);
        chk("byp0_hit", 32'(hit0), 0);
        idle(32'h300);
        #1 chk("byp0_next_hit", 32'(hit0), 1);

        // async reset takes effect before any clock edge
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'h300);
        #1 chk("arst_hit", 32'(hit0), 0); chk("arst_occ", 32'(occ0), 0);
        chk("arst_tgt", tgt0, 0);

        // random traffic over 12 tags (more than the table holds)
        for (int n = 0; n < 3000; n++) begin
            upc = 32'h1000 + 32'($urandom_range(0, 11) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) lpc = {upc[31:2], 2'($urandom_range(0, 3))};
            else lpc = 32'h1000 + 32'($urandom_range(0, 11) * 4) + 32'($urandom_range(0, 3));
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < 75),
                 ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 2),
                 upc, $urandom, lpc);
        end
        idle(32'h0);

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never checked, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
